// File: rtl/scoreboard_display_driver.sv
// rtl/scoreboard_display_driver.sv - BCD conversion and 4-digit multiplexed 7-segment driver for two player scores
//
// Purpose:
//   Converts two binary scores (0-99, larger values shown as 99) to BCD with a
//   sequential shift-add-3 engine whenever either score changes, then scans the
//   four digits onto a time-multiplexed common display.
//
// Optional feature (macro LEADING_ZERO_BLANK_EN):
//   When defined, a tens digit of 0 is shown blank. Otherwise it shows "0".
//
// Parameters:
//   REFRESH_DIV   clock cycles each digit stays enabled (2..65535)
//
// Ports:
//   clk_i         system clock
//   rst_ni        synchronous active-low reset
//   p1_score_i    player 1 binary score
//   p2_score_i    player 2 binary score
//   seg_o         registered segment pattern {g,f,e,d,c,b,a}, active-high
//   dp_o          registered decimal point, set on the player separator digit
//   digit_en_o    registered one-hot digit enable
//   conv_busy_o   high while a conversion is in progress

module scoreboard_display_driver #(
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] p1_score_i,
  input  logic [7:0] p2_score_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic [3:0] digit_en_o,
  output logic       conv_busy_o
);

  localparam int unsigned SCAN_W = $clog2(REFRESH_DIV);

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONV_P1 = 2'd1,
    CONV_P2 = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [7:0] p1_clamped;
  logic [7:0] p2_clamped;
  logic [7:0] p1_shadow;
  logic [7:0] p2_shadow;
  logic [2:0] iter;
  logic [7:0] bcd_work;    // {tens, ones} of the score currently being converted
  logic [7:0] p1_bcd_hold; // player 1 result parked while player 2 converts
  logic [3:0] p1_tens;
  logic [3:0] p1_ones;
  logic [3:0] p2_tens;
  logic [3:0] p2_ones;
  logic       score_changed;
  logic       bin_bit;
  logic [3:0] ones_adj;
  logic [2:0] tens_adj;
  logic [7:0] bcd_shifted;

  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit_idx;
  logic [3:0]        digit_val;
  logic              digit_blank;

  assign p1_clamped    = (p1_score_i > 8'd99) ? 8'd99 : p1_score_i;
  assign p2_clamped    = (p2_score_i > 8'd99) ? 8'd99 : p2_score_i;
  assign score_changed = (p1_clamped != p1_shadow) || (p2_clamped != p2_shadow);
  assign conv_busy_o   = (state != IDLE);

  // Binary bits are fed MSB first, selected by the iteration counter.
  assign bin_bit = (state == CONV_P2) ? p2_shadow[3'd7 - iter] : p1_shadow[3'd7 - iter];

  // Add-3 correction. The tens nibble never exceeds 9 for inputs <= 99, so its
  // top bit is always shifted out as zero and only the low three bits are kept.
  always_comb begin
    ones_adj = bcd_work[3:0];
    tens_adj = bcd_work[6:4];
    if (bcd_work[3:0] >= 4'd5) ones_adj = bcd_work[3:0] + 4'd3;
    if (bcd_work[7:4] >= 4'd5) tens_adj = bcd_work[6:4] + 3'd3;
  end

  assign bcd_shifted = {tens_adj, ones_adj, bin_bit};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (score_changed) state_next = CONV_P1;
      CONV_P1: if (iter == 3'd7)  state_next = CONV_P2;
      CONV_P2: if (iter == 3'd7)  state_next = COMMIT;
      COMMIT:                     state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- conversion datapath
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      iter        <= 3'd0;
      p1_shadow   <= 8'd0;
      p2_shadow   <= 8'd0;
      bcd_work    <= 8'd0;
      p1_bcd_hold <= 8'd0;
      p1_tens     <= 4'd0;
      p1_ones     <= 4'd0;
      p2_tens     <= 4'd0;
      p2_ones     <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (score_changed) begin
            p1_shadow <= p1_clamped;
            p2_shadow <= p2_clamped;
            bcd_work  <= 8'd0;
            iter      <= 3'd0;
          end
        end
        CONV_P1: begin
          iter <= iter + 3'd1;
          if (iter == 3'd7) begin
            p1_bcd_hold <= bcd_shifted;
            bcd_work    <= 8'd0;
          end else begin
            bcd_work <= bcd_shifted;
          end
        end
        CONV_P2: begin
          iter     <= iter + 3'd1;
          bcd_work <= bcd_shifted;
        end
        COMMIT: begin
          p1_tens <= p1_bcd_hold[7:4];
          p1_ones <= p1_bcd_hold[3:0];
          p2_tens <= bcd_work[7:4];
          p2_ones <= bcd_work[3:0];
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- digit scanning
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_W'(REFRESH_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    digit_val   = 4'd0;
    digit_blank = 1'b0;
    unique case (digit_idx)
      2'd0: digit_val = p2_ones;
      2'd1: begin
        digit_val   = p2_tens;
        digit_blank = BLANK_EN && (p2_tens == 4'd0);
      end
      2'd2: digit_val = p1_ones;
      2'd3: begin
        digit_val   = p1_tens;
        digit_blank = BLANK_EN && (p1_tens == 4'd0);
      end
      default: ;
    endcase
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] val);
    unique case (val)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      seg_o      <= 7'd0;
      dp_o       <= 1'b0;
      digit_en_o <= 4'b0000;
    end else begin
      seg_o      <= digit_blank ? 7'd0 : seg_decode(digit_val);
      dp_o       <= (digit_idx == 2'd2);
      digit_en_o <= 4'b0001 << digit_idx;
    end
  end

endmodule

// File: tb/tb_scoreboard_display_driver.sv
// tb/tb_scoreboard_display_driver.sv - scoreboard bench for scoreboard_display_driver

module tb_scoreboard_display_driver;

  localparam int R = 2;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] p1 = 8'd0;
  logic [7:0] p2 = 8'd0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] digit_en;
  logic       busy;

  always #5 clk = ~clk;

  scoreboard_display_driver #(.REFRESH_DIV(R)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .p1_score_i  (p1),
    .p2_score_i  (p2),
    .seg_o       (seg),
    .dp_o        (dp),
    .digit_en_o  (digit_en),
    .conv_busy_o (busy)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] en;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'h3F;  1: seg_of = 7'h06;  2: seg_of = 7'h5B;  3: seg_of = 7'h4F;
      4: seg_of = 7'h66;  5: seg_of = 7'h6D;  6: seg_of = 7'h7D;  7: seg_of = 7'h07;
      8: seg_of = 7'h7F;  9: seg_of = 7'h6F;  default: seg_of = 7'h00;
    endcase
  endfunction

  // Reference model: conversion takes effect 18 edges after the edge that
  // notices a changed clamped input; busy covers the 17 edges in between.
  int   m_cyc, m_busy, m_snap1, m_snap2, m_disp1, m_disp2;
  int   m_idx, m_val, c1, c2;
  bit   m_blank;
  exp_t m_e;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cyc = 0; m_busy = 0; m_snap1 = 0; m_snap2 = 0; m_disp1 = 0; m_disp2 = 0;
      m_e = '0;
    end else begin
      m_idx   = (m_cyc / R) % 4;
      m_blank = 1'b0;
      case (m_idx)
        0: m_val = m_disp2 % 10;
        1: begin m_val = m_disp2 / 10; m_blank = BLANK && (m_disp2 < 10); end
        2: m_val = m_disp1 % 10;
        default: begin m_val = m_disp1 / 10; m_blank = BLANK && (m_disp1 < 10); end
      endcase
      m_e.seg = m_blank ? 7'h00 : seg_of(m_val);
      m_e.dp  = (m_idx == 2);
      m_e.en  = 4'(1 << m_idx);
      m_cyc++;
      c1 = (int'(p1) > 99) ? 99 : int'(p1);
      c2 = (int'(p2) > 99) ? 99 : int'(p2);
      if (m_busy == 0) begin
        if (c1 != m_snap1 || c2 != m_snap2) begin
          m_snap1 = c1; m_snap2 = c2; m_busy = 17;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_disp1 = m_snap1; m_disp2 = m_snap2;
        end
      end
      m_e.busy = (m_busy != 0);
    end
    exp_q.push_back(m_e);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("seg", {1'b0, seg}, {1'b0, mon_e.seg});
      check("dp", {7'd0, dp}, {7'd0, mon_e.dp});
      check("digit_en", {4'd0, digit_en}, {4'd0, mon_e.en});
      check("conv_busy", {7'd0, busy}, {7'd0, mon_e.busy});
      if (mon_e.en != 4'd0) check("onehot", {7'd0, $onehot(digit_en)}, 8'd1);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; p1 = 8'd0; p2 = 8'd0;
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    p1 = 8'd57; p2 = 8'd9;
    cycles(30);
    p1 = 8'd200;
    cycles(30);
    p2 = 8'd3;
    cycles(5);
    p2 = 8'd42;
    cycles(45);
    p1 = 8'd88;
    cycles(12);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    cycles(30);
    for (int i = 0; i < 30; i++) begin
      p1 = 8'($urandom_range(0, 255));
      p2 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
      end
      cycles($urandom_range(1, 30));
    end
    cycles(45);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
